// File: rtl/hiscore_ram_responder.sv
// hiscore_ram_responder: serialises hiscore read/write requests into the
// single-port work RAM. The CPU keeps the port unless it is idle or paused.
// Optional build macro: HS_RESP_RANGE_CHECK_EN (address range check + hs_err).
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | CPU owns the port, waiting for a request and a free slot
// S_RD_ADDR | responder presents the read address to the RAM
// S_RD_DATA | RAM data returned, latched into hs_data_out, ack issued
// S_WR      | responder drives a one-cycle RAM write, ack issued
// S_DONE    | waiting for the initiator to drop its request level
module hiscore_ram_responder #(
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter int          RAM_AW   = 12
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_access_read,
  input  logic              hs_access_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_ack,
  output logic              hs_err,
  input  logic              pause,
  input  logic              cpu_cs,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we,
  output logic              cpu_wait,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic [RAM_AW-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_data_out;
  logic              r_ack;
  logic              r_oor;

  logic              w_slot;
  logic              w_req_oor;
  logic              w_own;

  // The CPU yields the port when it is not selecting RAM or when it is paused.
  assign w_slot = pause | ~cpu_cs;

`ifdef HS_RESP_RANGE_CHECK_EN
  localparam logic [16:0] RAM_END = {1'b0, RAM_BASE} + (17'd1 << RAM_AW);

  logic r_err;

  assign w_req_oor = ({1'b0, hs_address} <  {1'b0, RAM_BASE}) ||
                     ({1'b0, hs_address} >= RAM_END);

  // Error flag pulses together with the ack of an out-of-range request.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_oor && (r_state == S_RD_DATA || r_state == S_WR);
    end
  end

  assign hs_err = r_err;
`else
  logic w_unused_addr_hi;

  // Without the range check the upper address bits are simply dropped.
  assign w_unused_addr_hi = ^hs_address[15:RAM_AW];
  assign w_req_oor        = 1'b0;
  assign hs_err           = 1'b0;
`endif

  // Main sequencer: accepts requests in IDLE, runs the RAM cycle, acks once.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= 8'h00;
      r_data_out <= 8'h00;
      r_ack      <= 1'b0;
      r_oor      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hs_access_write && w_slot) begin
            r_addr  <= hs_address[RAM_AW-1:0];
            r_wdata <= hs_data_in;
            r_oor   <= w_req_oor;
            r_state <= S_WR;
          end else if (hs_access_read && w_slot) begin
            r_addr  <= hs_address[RAM_AW-1:0];
            r_oor   <= w_req_oor;
            // Out-of-range reads skip the RAM access entirely.
            r_state <= w_req_oor ? S_RD_DATA : S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          r_data_out <= r_oor ? 8'h00 : ram_dout;
          r_ack      <= 1'b1;
          r_state    <= S_DONE;
        end
        S_WR: begin
          r_ack   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!hs_access_read && !hs_access_write) begin
            r_state <= S_IDLE;
            r_oor   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The responder owns the port only while running a real in-range RAM cycle.
  assign w_own = ((r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                  (r_state == S_WR)) && !r_oor;

  // Port mux: CPU pass-through unless the responder owns the port. The write
  // strobe is gated by reset_n so a reset asserted during WR blocks the write.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = cpu_cs & cpu_we;
    if (w_own) begin
      ram_addr = r_addr;
      ram_din  = r_wdata;
      ram_we   = (r_state == S_WR) && reset_n;
    end
  end

  assign cpu_wait    = w_own & cpu_cs;
  assign hs_ack      = r_ack;
  assign hs_data_out = r_data_out;

endmodule

// File: tb/tb_hiscore_ram_responder.sv
// Directed bench for hiscore_ram_responder with a behavioural 1-cycle RAM.
module tb_hiscore_ram_responder;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_access_read;
  logic        hs_access_write;
  logic [7:0]  hs_data_out;
  logic        hs_ack;
  logic        hs_err;
  logic        pause;
  logic        cpu_cs;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_wait;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:4095];
  int          total = 0;
  int          bad   = 0;

  hiscore_ram_responder #(.RAM_BASE(16'h8000), .RAM_AW(12)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .hs_address(hs_address), .hs_data_in(hs_data_in),
    .hs_access_read(hs_access_read), .hs_access_write(hs_access_write),
    .hs_data_out(hs_data_out), .hs_ack(hs_ack), .hs_err(hs_err),
    .pause(pause), .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // Single-port RAM, read-before-write, 1-cycle read latency
  always @(posedge clk_sys) begin
    logic [7:0] rd;
    rd = mem[ram_addr];
    if (ram_we === 1'b1) mem[ram_addr] = ram_din;
    ram_dout <= rd;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    int n;
    mem[12'h055] = 8'hA5;
    reset_n = 1'b0; pause = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0;
    cpu_addr = 12'h3FF; cpu_din = 8'h00;
    hs_access_read = 1'b1; hs_access_write = 1'b0;
    hs_address = 16'h8055; hs_data_in = 8'h00;
    tick(); tick();
    total++; if (hs_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", hs_ack); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    total++; if (hs_data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", hs_data_out); end
    total++; if (cpu_wait !== 1'b0) begin bad++; $display("FAIL reset_cpu_wait got=%b exp=0", cpu_wait); end
    reset_n = 1'b1;
    n = 0;
    while (hs_ack !== 1'b1 && n < 10) begin tick(); n++; end
    total++; if (n != 3) begin bad++; $display("FAIL reset_release_latency got=%0d exp=3", n); end
    total++; if (hs_data_out !== 8'hA5) begin bad++; $display("FAIL reset_release_data got=%h exp=a5", hs_data_out); end
    hs_access_read = 1'b0;
    tick();
  endtask

  task automatic test_read();
    mem[12'h123] = 8'h5A;
    cpu_cs = 1'b1; cpu_addr = 12'h3FF; pause = 1'b1;
    hs_address = 16'h8123; hs_access_read = 1'b1;
    tick();
    total++; if (ram_addr !== 12'h123 || ram_we !== 1'b0 || cpu_wait !== 1'b1 || hs_ack !== 1'b0) begin
      bad++; $display("FAIL read_k1 addr=%h we=%b wait=%b ack=%b exp 123/0/1/0", ram_addr, ram_we, cpu_wait, hs_ack); end
    tick();
    total++; if (hs_ack !== 1'b0) begin bad++; $display("FAIL read_k2_ack got=%b exp=0", hs_ack); end
    tick();
    total++; if (hs_ack !== 1'b1 || hs_data_out !== 8'h5A || hs_err !== 1'b0) begin
      bad++; $display("FAIL read_k3 ack=%b data=%h err=%b exp 1/5a/0", hs_ack, hs_data_out, hs_err); end
    tick();
    total++; if (hs_ack !== 1'b0 || hs_data_out !== 8'h5A || cpu_wait !== 1'b0 || ram_addr !== 12'h3FF) begin
      bad++; $display("FAIL read_k4 ack=%b data=%h wait=%b addr=%h exp 0/5a/0/3ff", hs_ack, hs_data_out, cpu_wait, ram_addr); end
    hs_access_read = 1'b0;
    tick();
  endtask

  task automatic test_write_contention();
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_din = 8'h11; pause = 1'b0;
    hs_address = 16'h8010; hs_data_in = 8'hC3; hs_access_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (hs_ack !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 12'h200 || cpu_wait !== 1'b0) begin
        bad++; $display("FAIL wr_blocked cyc=%0d ack=%b we=%b addr=%h wait=%b exp 0/1/200/0", i, hs_ack, ram_we, ram_addr, cpu_wait); end
    end
    pause = 1'b1;
    tick();
    total++; if (ram_we !== 1'b1 || ram_addr !== 12'h010 || ram_din !== 8'hC3 || cpu_wait !== 1'b1 || hs_ack !== 1'b0) begin
      bad++; $display("FAIL wr_cycle we=%b addr=%h din=%h wait=%b ack=%b exp 1/010/c3/1/0", ram_we, ram_addr, ram_din, cpu_wait, hs_ack); end
    tick();
    total++; if (hs_ack !== 1'b1 || cpu_wait !== 1'b0 || ram_addr !== 12'h200) begin
      bad++; $display("FAIL wr_ack ack=%b wait=%b addr=%h exp 1/0/200", hs_ack, cpu_wait, ram_addr); end
    total++; if (mem[12'h010] !== 8'hC3) begin bad++; $display("FAIL wr_mem010 got=%h exp=c3", mem[12'h010]); end
    total++; if (mem[12'h200] !== 8'h11) begin bad++; $display("FAIL wr_cpu_mem200 got=%h exp=11", mem[12'h200]); end
    hs_access_write = 1'b0; cpu_we = 1'b0; cpu_cs = 1'b0;
    tick();
  endtask

  task automatic test_both();
    mem[12'h020] = 8'h00;
    hs_address = 16'h8020; hs_data_in = 8'h77;
    hs_access_read = 1'b1; hs_access_write = 1'b1;
    tick();
    total++; if (ram_we !== 1'b1 || ram_addr !== 12'h020 || ram_din !== 8'h77) begin
      bad++; $display("FAIL both_wr we=%b addr=%h din=%h exp 1/020/77", ram_we, ram_addr, ram_din); end
    tick();
    total++; if (hs_ack !== 1'b1 || hs_data_out !== 8'h5A) begin
      bad++; $display("FAIL both_ack ack=%b data=%h exp 1/5a", hs_ack, hs_data_out); end
    total++; if (mem[12'h020] !== 8'h77) begin bad++; $display("FAIL both_mem020 got=%h exp=77", mem[12'h020]); end
    hs_access_read = 1'b0; hs_access_write = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    mem[12'h000] = 8'h3C;
    cpu_cs = 1'b1; cpu_addr = 12'h3FF; pause = 1'b1;
    hs_address = 16'h9000; hs_access_read = 1'b1;
    tick();
`ifdef HS_RESP_RANGE_CHECK_EN
    total++; if (ram_we !== 1'b0 || cpu_wait !== 1'b0 || ram_addr !== 12'h3FF || hs_ack !== 1'b0) begin
      bad++; $display("FAIL oor_k1 we=%b wait=%b addr=%h ack=%b exp 0/0/3ff/0", ram_we, cpu_wait, ram_addr, hs_ack); end
    tick();
    total++; if (hs_ack !== 1'b1 || hs_err !== 1'b1 || hs_data_out !== 8'h00) begin
      bad++; $display("FAIL oor_ack ack=%b err=%b data=%h exp 1/1/00", hs_ack, hs_err, hs_data_out); end
    tick();
    total++; if (hs_ack !== 1'b0 || hs_err !== 1'b0) begin
      bad++; $display("FAIL oor_after ack=%b err=%b exp 0/0", hs_ack, hs_err); end
`else
    total++; if (ram_addr !== 12'h000 || cpu_wait !== 1'b1) begin
      bad++; $display("FAIL trunc_k1 addr=%h wait=%b exp 000/1", ram_addr, cpu_wait); end
    tick(); tick();
    total++; if (hs_ack !== 1'b1 || hs_data_out !== 8'h3C || hs_err !== 1'b0) begin
      bad++; $display("FAIL trunc_ack ack=%b data=%h err=%b exp 1/3c/0", hs_ack, hs_data_out, hs_err); end
    tick();
`endif
    hs_access_read = 1'b0; cpu_cs = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    mem[12'h0AB] = 8'hE1;
    mem[12'h040] = 8'h00;
    hs_address = 16'h80AB; hs_access_read = 1'b1;
    tick();
    total++; if (ram_addr !== 12'h0AB) begin bad++; $display("FAIL wd_addr got=%h exp=0ab", ram_addr); end
    hs_access_read = 1'b0;
    tick();
    total++; if (hs_ack !== 1'b0) begin bad++; $display("FAIL wd_k2_ack got=%b exp=0", hs_ack); end
    tick();
    total++; if (hs_ack !== 1'b1 || hs_data_out !== 8'hE1) begin
      bad++; $display("FAIL wd_ack ack=%b data=%h exp 1/e1", hs_ack, hs_data_out); end
    tick();
    total++; if (hs_ack !== 1'b0) begin bad++; $display("FAIL wd_k4_ack got=%b exp=0", hs_ack); end
    hs_address = 16'h8040; hs_data_in = 8'h5D; hs_access_write = 1'b1;
    tick();
    total++; if (ram_we !== 1'b1 || ram_addr !== 12'h040) begin
      bad++; $display("FAIL wd_next_wr we=%b addr=%h exp 1/040", ram_we, ram_addr); end
    tick();
    total++; if (hs_ack !== 1'b1 || mem[12'h040] !== 8'h5D) begin
      bad++; $display("FAIL wd_next_ack ack=%b mem=%h exp 1/5d", hs_ack, mem[12'h040]); end
    hs_access_write = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    mem[12'h030] = 8'h00;
    hs_address = 16'h8030; hs_data_in = 8'h99; hs_access_write = 1'b1;
    tick();
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL rmid_wr_start got=%b exp=1", ram_we); end
    reset_n = 1'b0;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rmid_we_gated got=%b exp=0", ram_we); end
    tick();
    total++; if (hs_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%b exp=0", hs_ack); end
    total++; if (mem[12'h030] !== 8'h00) begin bad++; $display("FAIL rmid_mem030 got=%h exp=00", mem[12'h030]); end
    hs_access_write = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (hs_ack !== 1'b0 || hs_data_out !== 8'h00 || ram_we !== 1'b0) begin
      bad++; $display("FAIL rmid_after ack=%b data=%h we=%b exp 0/00/0", hs_ack, hs_data_out, ram_we); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_read();
    test_write_contention();
    test_both();
    test_out_of_range();
    test_withdraw();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
